// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM state encodings,
// the per-stage control bundle and the constructors for common stall patterns.
package pipe_hazard_ctrl_pkg;

  localparam int HZ_XLEN          = 32;
  localparam int HZ_MC_MAX_CYCLES = 40;
  localparam int HZ_MC_CNT_W      = 6;

  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_MEMWAIT = 2'd1,
    HZ_MCWAIT  = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic hold_pc;
    logic hold_if_id;
    logic hold_id_ex;
    logic hold_ex_mem;
    logic hold_mem_wb;
    logic bubble_id_ex;
    logic bubble_ex_mem;
    logic flush_if_id;
  } hz_ctrl_t;

  // Whole pipeline frozen: data memory is not ready.
  function automatic hz_ctrl_t hz_hold_all();
    hz_ctrl_t c;
    c             = '0;
    c.hold_pc     = 1'b1;
    c.hold_if_id  = 1'b1;
    c.hold_id_ex  = 1'b1;
    c.hold_ex_mem = 1'b1;
    c.hold_mem_wb = 1'b1;
    return c;
  endfunction

  // Front end frozen behind a multi-cycle EX op; MEM/WB keep draining.
  function automatic hz_ctrl_t hz_mc_stall();
    hz_ctrl_t c;
    c               = '0;
    c.hold_pc       = 1'b1;
    c.hold_if_id    = 1'b1;
    c.hold_id_ex    = 1'b1;
    c.bubble_ex_mem = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard indications from the pipeline and the stall/flush/redirect controls
// returned to it. The pipeline side is the master, the sequencer the slave.
interface pipe_hazard_ctrl_if #(
  parameter int XLEN = 32
);

  logic            load_use_flag;
  logic            branch_taken_ex;
  logic [XLEN-1:0] branch_target_ex;
  logic            mc_start_ex;
  logic            mc_done;
  logic            mem_busy;
  logic            trap_req;
  logic [XLEN-1:0] trap_vec;

  logic            hold_pc;
  logic            hold_if_id;
  logic            hold_id_ex;
  logic            hold_ex_mem;
  logic            hold_mem_wb;
  logic            bubble_id_ex;
  logic            bubble_ex_mem;
  logic            flush_if_id;
  logic            redirect_vld;
  logic [XLEN-1:0] redirect_pc;
  logic            mc_timeout;
  logic [1:0]      state_o;

  modport master (
    output load_use_flag, branch_taken_ex, branch_target_ex, mc_start_ex,
           mc_done, mem_busy, trap_req, trap_vec,
    input  hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, hold_mem_wb,
           bubble_id_ex, bubble_ex_mem, flush_if_id, redirect_vld,
           redirect_pc, mc_timeout, state_o
  );

  modport slave (
    input  load_use_flag, branch_taken_ex, branch_target_ex, mc_start_ex,
           mc_done, mem_busy, trap_req, trap_vec,
    output hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, hold_mem_wb,
           bubble_id_ex, bubble_ex_mem, flush_if_id, redirect_vld,
           redirect_pc, mc_timeout, state_o
  );

endinterface

// File: rtl/pipe_hazard_mc_watchdog.sv
// Cycle counter for an outstanding multi-cycle EX op, with a saturating limit
// check and a sticky timeout flag that only reset clears.
module pipe_hazard_mc_watchdog
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MC_MAX_CYCLES = HZ_MC_MAX_CYCLES,
  parameter int MC_CNT_W      = HZ_MC_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  input  logic clear,
  input  logic done,
  output logic expired,
  output logic timeout
);

  localparam logic [MC_CNT_W-1:0] MAX_CNT = MC_CNT_W'(MC_MAX_CYCLES);

  logic [MC_CNT_W-1:0] cnt;

  assign expired = (cnt >= MAX_CNT);

  // Counting stops at the limit so a long memory stall cannot wrap it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      if (clear)
        cnt <= '0;
      else if (start)
        cnt <= MC_CNT_W'(1);
      else if (run && !expired)
        cnt <= cnt + MC_CNT_W'(1);
      if (run && expired && !done)
        timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: priority decode of hazards,
// memory and multi-cycle wait states, and a deferred trap latch.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int XLEN          = HZ_XLEN,
  parameter int MC_MAX_CYCLES = HZ_MC_MAX_CYCLES,
  parameter int MC_CNT_W      = HZ_MC_CNT_W
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  hz_state_e       state, state_nxt;
  hz_ctrl_t        ctl;
  logic            redirect_vld;
  logic [XLEN-1:0] redirect_pc;
  logic            trap_pend;
  logic [XLEN-1:0] trap_vec_q;
  logic            trap_set, trap_clr;
  logic            wd_start, wd_run, wd_clear, wd_expired, wd_timeout;

  pipe_hazard_mc_watchdog #(
    .MC_MAX_CYCLES (MC_MAX_CYCLES),
    .MC_CNT_W      (MC_CNT_W)
  ) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (wd_start),
    .run     (wd_run),
    .clear   (wd_clear),
    .done    (hz.mc_done),
    .expired (wd_expired),
    .timeout (wd_timeout)
  );

  // MEMWAIT with memory free is decoded exactly like RUN.
  always_comb begin
    ctl          = '0;
    redirect_vld = 1'b0;
    redirect_pc  = '0;
    state_nxt    = state;
    trap_set     = 1'b0;
    trap_clr     = 1'b0;
    wd_start     = 1'b0;
    wd_run       = 1'b0;
    wd_clear     = 1'b0;
    if (state == HZ_MCWAIT) begin
      wd_run   = 1'b1;
      trap_set = hz.trap_req;
      if (hz.mem_busy) begin
        ctl = hz_hold_all();
      end else if (hz.mc_done || wd_expired) begin
        state_nxt = HZ_RUN;
        wd_clear  = 1'b1;
      end else begin
        ctl = hz_mc_stall();
      end
    end else if (hz.mem_busy) begin
      ctl       = hz_hold_all();
      trap_set  = hz.trap_req;
      state_nxt = HZ_MEMWAIT;
    end else begin
      state_nxt = HZ_RUN;
      if (hz.trap_req || trap_pend) begin
        redirect_vld      = 1'b1;
        redirect_pc       = trap_pend ? trap_vec_q : hz.trap_vec;
        ctl.flush_if_id   = 1'b1;
        ctl.bubble_id_ex  = 1'b1;
        ctl.bubble_ex_mem = 1'b1;
        trap_clr          = 1'b1;
      end else if (hz.branch_taken_ex) begin
        redirect_vld     = 1'b1;
        redirect_pc      = hz.branch_target_ex;
        ctl.flush_if_id  = 1'b1;
        ctl.bubble_id_ex = 1'b1;
      end else if (hz.mc_start_ex && !hz.mc_done) begin
        ctl       = hz_mc_stall();
        wd_start  = 1'b1;
        state_nxt = HZ_MCWAIT;
      end else if (hz.load_use_flag) begin
        ctl.hold_pc      = 1'b1;
        ctl.hold_if_id   = 1'b1;
        ctl.bubble_id_ex = 1'b1;
      end
    end
  end

  // A trap arriving while the pipe is frozen is parked; the first one wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HZ_RUN;
      trap_pend  <= 1'b0;
      trap_vec_q <= '0;
    end else begin
      state <= state_nxt;
      if (trap_clr) begin
        trap_pend <= 1'b0;
      end else if (trap_set && !trap_pend) begin
        trap_pend  <= 1'b1;
        trap_vec_q <= hz.trap_vec;
      end
    end
  end

  assign hz.hold_pc       = rst_n & ctl.hold_pc;
  assign hz.hold_if_id    = rst_n & ctl.hold_if_id;
  assign hz.hold_id_ex    = rst_n & ctl.hold_id_ex;
  assign hz.hold_ex_mem   = rst_n & ctl.hold_ex_mem;
  assign hz.hold_mem_wb   = rst_n & ctl.hold_mem_wb;
  assign hz.bubble_id_ex  = rst_n & ctl.bubble_id_ex;
  assign hz.bubble_ex_mem = rst_n & ctl.bubble_ex_mem;
  assign hz.flush_if_id   = rst_n & ctl.flush_if_id;
  assign hz.redirect_vld  = rst_n & redirect_vld;
  assign hz.redirect_pc   = rst_n ? redirect_pc : '0;
  assign hz.mc_timeout    = wd_timeout;
  assign hz.state_o       = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, branch, multi-cycle wait,
// watchdog timeout, memory wait with deferred trap, and async reset.
module tb_pipe_hazard_ctrl;

  localparam logic [8:0] NONE = 9'b00000_0000;
  localparam logic [8:0] ALL  = 9'b11111_0000;
  localparam logic [8:0] LU   = 9'b11000_1000;
  localparam logic [8:0] MCST = 9'b11100_0100;
  localparam logic [8:0] BR   = 9'b00000_1011;
  localparam logic [8:0] TRAP = 9'b00000_1111;

  localparam logic [1:0] ST_RUN = 2'd0;
  localparam logic [1:0] ST_MEM = 2'd1;
  localparam logic [1:0] ST_MC  = 2'd2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.XLEN(32)) hz ();

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  function automatic logic [43:0] observe();
    return {hz.hold_pc, hz.hold_if_id, hz.hold_id_ex, hz.hold_ex_mem,
            hz.hold_mem_wb, hz.bubble_id_ex, hz.bubble_ex_mem,
            hz.flush_if_id, hz.redirect_vld, hz.redirect_pc,
            hz.mc_timeout, hz.state_o};
  endfunction

  task automatic driveInputs(input logic lu, input logic br,
                             input logic [31:0] tgt, input logic mcs,
                             input logic mcd, input logic mb,
                             input logic tr, input logic [31:0] tv);
    hz.load_use_flag    = lu;
    hz.branch_taken_ex  = br;
    hz.branch_target_ex = tgt;
    hz.mc_start_ex      = mcs;
    hz.mc_done          = mcd;
    hz.mem_busy         = mb;
    hz.trap_req         = tr;
    hz.trap_vec         = tv;
  endtask

  // Inputs change just after the rising edge; outputs are sampled mid-cycle.
  task automatic applyStimulus(input logic lu, input logic br,
                               input logic [31:0] tgt, input logic mcs,
                               input logic mcd, input logic mb,
                               input logic tr, input logic [31:0] tv);
    @(posedge clk);
    #1;
    driveInputs(lu, br, tgt, mcs, mcd, mb, tr, tv);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [8:0] ctl,
                             input logic [31:0] pc, input logic to,
                             input logic [1:0] st);
    logic [43:0] exp_v;
    logic [43:0] obs_v;
    exp_v = {ctl, pc, to, st};
    obs_v = observe();
    checks++;
    assert (obs_v === exp_v)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs_v, exp_v);
    end
  endtask

  task automatic checkCount(input string tag, input logic [5:0] exp_cnt);
    logic [5:0] obs_cnt;
    obs_cnt = dut.u_wd.cnt;
    checks++;
    assert (obs_cnt === exp_cnt)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs_cnt, exp_cnt);
    end
  endtask

  initial begin
    // Reset held with every hazard input active: outputs must stay low.
    driveInputs(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 32'h4000_0000);
    @(negedge clk);
    checkOutput("reset_outputs", NONE, 32'h0, 1'b0, ST_RUN);
    checkCount("reset_cnt", 6'd0);
    driveInputs(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1 rst_n = 1'b1;

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("idle", NONE, 32'h0, 1'b0, ST_RUN);

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("load_use", LU, 32'h0, 1'b0, ST_RUN);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("load_use_one_cycle", NONE, 32'h0, 1'b0, ST_RUN);

    applyStimulus(1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("branch_over_load_use", BR, 32'h0000_0100, 1'b0, ST_RUN);

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("mc_done_same_cycle", NONE, 32'h0, 1'b0, ST_RUN);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("mc_done_same_cycle_next", NONE, 32'h0, 1'b0, ST_RUN);

    // Multi-cycle op completing 33 cycles after it was issued.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("mc_start", MCST, 32'h0, 1'b0, ST_RUN);
    for (int i = 1; i <= 32; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("mc_wait", MCST, 32'h0, 1'b0, ST_MC);
      if (i == 10) checkCount("mc_cnt_10", 6'd10);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("mc_done_release", NONE, 32'h0, 1'b0, ST_MC);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("mc_back_to_run", NONE, 32'h0, 1'b0, ST_RUN);
    checkCount("mc_cnt_cleared", 6'd0);

    // Memory wait with a trap parked mid-stall; the second request is ignored.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("mem_busy_1", ALL, 32'h0, 1'b0, ST_RUN);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0000);
    checkOutput("mem_busy_2", ALL, 32'h0, 1'b0, ST_MEM);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD_0000);
    checkOutput("mem_busy_3", ALL, 32'h0, 1'b0, ST_MEM);
    applyStimulus(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1234);
    checkOutput("trap_deferred", TRAP, 32'h8000_0000, 1'b0, ST_MEM);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("trap_pend_cleared", NONE, 32'h0, 1'b0, ST_RUN);

    applyStimulus(1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
    checkOutput("trap_over_branch", TRAP, 32'h0000_0200, 1'b0, ST_RUN);

    // Multi-cycle op that never completes: watchdog releases at cycle 40.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wd_start", MCST, 32'h0, 1'b0, ST_RUN);
    for (int i = 1; i <= 39; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("wd_wait", MCST, 32'h0, 1'b0, ST_MC);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wd_release", NONE, 32'h0, 1'b0, ST_MC);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wd_timeout_set", NONE, 32'h0, 1'b1, ST_RUN);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wd_timeout_sticky", LU, 32'h0, 1'b1, ST_RUN);

    // Async reset in the middle of a multi-cycle wait.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("mc2_start", MCST, 32'h0, 1'b1, ST_RUN);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("mc2_wait", MCST, 32'h0, 1'b1, ST_MC);
    end
    checkCount("mc2_cnt_10", 6'd10);
    #1;
    driveInputs(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_mc", NONE, 32'h0, 1'b0, ST_RUN);
    checkCount("reset_mid_mc_cnt", 6'd0);
    driveInputs(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1 rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("after_reset", NONE, 32'h0, 1'b0, ST_RUN);
    checkCount("after_reset_cnt", 6'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL sim_time_limit: observed still running expected finished");
    $fatal(1, "[TB] time limit exceeded");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Consumes hazard indications (load_use_flag from the hazard/forward logic, taken branch in EX, multi-cycle EX op, data-memory wait, trap request).
- Drives per-stage hold/bubble/flush controls and the PC redirect.
- Owns the only sequential hazard state: memory-wait state, multi-cycle wait with watchdog, and deferred trap latch.

Parameters:
XLEN, 32, PC/target width
MC_MAX_CYCLES, 40, watchdog limit for a multi-cycle EX op before forced release
MC_CNT_W, 6, counter width; must hold MC_MAX_CYCLES

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_use_flag  in  1  load in ID/EX, dependent instr in IF/ID
branch_taken_ex  in  1  branch/jump in EX resolved taken
branch_target_ex  in  XLEN  redirect target for taken branch
mc_start_ex  in  1  valid multi-cycle op (div/rem) in EX this cycle
mc_done  in  1  multi-cycle unit result valid
mem_busy  in  1  data memory not ready for instr in MEM
trap_req  in  1  exception/interrupt request
trap_vec  in  XLEN  trap handler address
hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, hold_mem_wb  out  1 each  stage register keeps value
bubble_id_ex, bubble_ex_mem  out  1 each  load NOP into that register
flush_if_id  out  1  load NOP into IF/ID
redirect_vld  out  1  PC loads redirect_pc next edge
redirect_pc  out  XLEN  redirect address
mc_timeout  out  1  sticky: watchdog fired
state_o  out  2  current FSM state (debug)

Behaviour:
- All control outputs are Mealy, combinational from state + inputs. Registers: state, mc_cnt, trap_pend, trap_vec_q, mc_timeout.
- Reset: async clear. State RUN, mc_cnt=0, trap_pend=0, trap_vec_q=0, mc_timeout=0. While rst_n=0, all outputs are 0.
- States (encodings in define.v): RUN=0, MEMWAIT=1, MCWAIT=2.
- RUN priority, highest first:
  1. mem_busy: assert all five holds; no bubble, flush or redirect; next MEMWAIT.
  2. trap_req or trap_pend: redirect_vld=1; redirect_pc=trap_vec_q if trap_pend, else trap_vec; flush_if_id, bubble_id_ex and bubble_ex_mem=1 (EX instr killed); clear trap_pend.
  3. branch_taken_ex: redirect_vld=1, redirect_pc=branch_target_ex, flush_if_id=1, bubble_id_ex=1. Suppresses load_use_flag and mc_start_ex; the EX instr is a branch, so the ID-stage op is wrong-path.
  4. mc_start_ex and !mc_done: hold_pc, hold_if_id, hold_id_ex, bubble_ex_mem; mc_cnt<=1; next MCWAIT. If mc_start_ex and mc_done in the same cycle: no stall.
  5. load_use_flag: hold_pc, hold_if_id, bubble_id_ex for exactly that cycle; stay RUN. The flag drops once the load advances.
- MEMWAIT:
  - mem_busy=1: all holds asserted.
  - mem_busy=0: the cycle is evaluated with the RUN priorities, and the next state follows RUN.
- MCWAIT:
  - Each cycle: hold_pc, hold_if_id, hold_id_ex, bubble_ex_mem; mc_cnt++.
  - mem_busy=1 additionally holds ex_mem and mem_wb and suppresses bubble_ex_mem.
  - mc_done=1 with mem_busy=0: no holds or bubbles; result enters EX/MEM; next RUN; mc_cnt<=0.
  - mc_done=1 with mem_busy=1: stay MCWAIT with all holds asserted; release on the first cycle with mem_busy=0.
  - mc_cnt==MC_MAX_CYCLES without done: set mc_timeout; release as if done; next RUN.
- Deferred trap: trap_req seen in MEMWAIT, MCWAIT, or RUN case 1 sets trap_pend and captures trap_vec into trap_vec_q. The first request wins; later requests are ignored until the trap is taken.
- mc_timeout clears only on reset.
- mc_cnt saturates; it never wraps.

Decomposition:
- define.v gets the state encodings (`HZ_RUN/`HZ_MEMWAIT/`HZ_MCWAIT) and XLEN.
- One sub-module, pipe_hazard_mc_watchdog: mc_cnt load/increment/clear, with expired and sticky timeout outputs.
- FSM and priority decode stay in the top module.

Test Plan:
- load_use_flag=1 one cycle in RUN -> hold_pc=hold_if_id=bubble_id_ex=1 that cycle only; state stays 0.
- branch_taken_ex=1, target 0x0000_0100, load_use_flag=1 same cycle -> redirect_vld=1, redirect_pc=0x100, flush_if_id=1, bubble_id_ex=1, hold_pc=0.
- mc_start_ex=1, mc_done after 33 cycles -> 33 cycles of hold_pc/if_id/id_ex plus bubble_ex_mem, release on the done cycle, state 2->0, mc_timeout=0.
- mc_start_ex=1, mc_done never -> release at cycle 40, mc_timeout=1 until reset.
- mem_busy=1 for 3 cycles with trap_req pulse (vec 0x8000_0000) in cycle 2 -> all holds for 3 cycles; first free cycle gives redirect_pc=0x8000_0000 with flush/bubbles; trap_pend cleared.
- rst_n low during MCWAIT at count 10 -> all outputs 0 immediately; after release state 0, mc_cnt=0, no stall.
